issue_ctrl: RTL and testbench

- Dual-issue scheduler between the ID issue buffer and the two execution pipes (A and B).
- Each cycle it inspects the two head entries of the issue buffer and decides how many to pop: 0, 1 (A only) or 2. That count drives the buffer's consume input combinationally.
- It tracks in-flight load destinations for load-use interlock.
- It sequences serializing instructions (CSR write, ertn, ibar, idle) through a drain state machine.

---
 rtl/issue_if.sv | 49 ++++
 rtl/issue_ctrl.sv | 169 ++++++++++++++++
 tb/tb_issue_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_if.sv
// rtl/issue_if.sv - issue buffer head to issue_ctrl bundle
// Purpose: carries the two head entries of the issue buffer (slot A, slot B)
//          and the pop/issue decision back to the buffer and the pipes.
// Signals:
//   i_is_valid[1:0]            head validity (bit1 = slot A, bit0 = slot B)
//   a_*/b_*                    decoded fields of slot A / slot B
//   o_usingNUM[1:0]            entries consumed this cycle
//   o_issue_a / o_issue_b      per-pipe issue strobes
// Modports: master = issue buffer side, slave = issue_ctrl.
interface issue_if;
    logic [1:0] i_is_valid;
    logic [4:0] a_rf_rd;
    logic [4:0] b_rf_rd;
    logic       a_rf_we;
    logic       b_rf_we;
    logic [4:0] a_rf_raddr1;
    logic [4:0] a_rf_raddr2;
    logic [4:0] b_rf_raddr1;
    logic [4:0] b_rf_raddr2;
    logic       a_is_load;
    logic       b_is_load;
    logic       a_is_mem;
    logic       b_is_mem;
    logic       a_is_br;
    logic       b_is_br;
    logic       a_is_muldiv;
    logic       b_is_muldiv;
    logic       a_is_serial;
    logic       b_is_serial;
    logic [1:0] o_usingNUM;
    logic       o_issue_a;
    logic       o_issue_b;

    modport master (
        output i_is_valid, a_rf_rd, b_rf_rd, a_rf_we, b_rf_we,
               a_rf_raddr1, a_rf_raddr2, b_rf_raddr1, b_rf_raddr2,
               a_is_load, b_is_load, a_is_mem, b_is_mem, a_is_br, b_is_br,
               a_is_muldiv, b_is_muldiv, a_is_serial, b_is_serial,
        input  o_usingNUM, o_issue_a, o_issue_b
    );

    modport slave (
        input  i_is_valid, a_rf_rd, b_rf_rd, a_rf_we, b_rf_we,
               a_rf_raddr1, a_rf_raddr2, b_rf_raddr1, b_rf_raddr2,
               a_is_load, b_is_load, a_is_mem, b_is_mem, a_is_br, b_is_br,
               a_is_muldiv, b_is_muldiv, a_is_serial, b_is_serial,
        output o_usingNUM, o_issue_a, o_issue_b
    );
endinterface

// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - dual-issue scheduler with load-use interlock and serializing drain
// Purpose: decides each cycle whether 0, 1 (slot A) or 2 head entries issue to
//          pipes A/B, tracks in-flight load destinations, and holds issue for
//          SERIAL_DRAIN unstalled cycles after a serializing instruction.
// Ports:
//   clk, rstn (async, active low)
//   ib            issue_if.slave: head entries in, o_usingNUM/o_issue_a/o_issue_b out
//   flush_BR      branch flush (clears scoreboard and drain state)
//   stall_DCache, stall_div   pipeline stalls
//   o_serial_busy drain FSM not in NORMAL
//   o_cnt_dual, o_cnt_single, o_cnt_zero   perf counters (only with ISSUE_PERF_CNT_EN)
// Optional feature macro: ISSUE_PERF_CNT_EN
module issue_ctrl #(
    parameter int LOAD_LAT     = 2,
    parameter int SERIAL_DRAIN = 3
) (
    input  logic        clk,
    input  logic        rstn,
    issue_if.slave      ib,
    input  logic        flush_BR,
    input  logic        stall_DCache,
    input  logic        stall_div,
    output logic        o_serial_busy
`ifdef ISSUE_PERF_CNT_EN
    ,
    output logic [31:0] o_cnt_dual,
    output logic [31:0] o_cnt_single,
    output logic [31:0] o_cnt_zero
`endif
);

    localparam int          SB_N       = LOAD_LAT - 1;
    localparam logic [3:0]  DRAIN_INIT = 4'(SERIAL_DRAIN);

    typedef enum logic {S_NORMAL, S_DRAIN} state_t;

    state_t          state, state_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic [SB_N-1:0] sb_vld;
    logic [4:0]      sb_rd [SB_N];

    logic stall;
    logic hit_a, hit_b, sb_any, pair_block;
    logic issue_a, issue_b;
    logic push_a, push_b;
    logic unused_br;

    // Slot B branch-ness never restricts the pair: only A's branch splits it.
    assign unused_br = ib.b_is_br;

    assign stall = stall_DCache | stall_div;

    // r0 is hard-wired zero, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    always_comb begin
        hit_a  = 1'b0;
        hit_b  = 1'b0;
        sb_any = 1'b0;
        for (int i = 0; i < SB_N; i++) begin
            if (sb_vld[i]) begin
                sb_any = 1'b1;
                if (reg_match(sb_rd[i], ib.a_rf_raddr1) || reg_match(sb_rd[i], ib.a_rf_raddr2))
                    hit_a = 1'b1;
                if (reg_match(sb_rd[i], ib.b_rf_raddr1) || reg_match(sb_rd[i], ib.b_rf_raddr2))
                    hit_b = 1'b1;
            end
        end

        pair_block = (ib.a_rf_we && (reg_match(ib.a_rf_rd, ib.b_rf_raddr1) ||
                                     reg_match(ib.a_rf_rd, ib.b_rf_raddr2)))
                   || (ib.a_is_mem && ib.b_is_mem)
                   || ib.a_is_br
                   || (ib.a_is_muldiv && ib.b_is_muldiv)
                   || ib.a_is_serial || ib.b_is_serial;

        // rstn gates the strobes so outputs are quiet during reset.
        issue_a = rstn && ib.i_is_valid[1] && !stall && !flush_BR && (state == S_NORMAL)
                  && !hit_a && !(ib.a_is_serial && sb_any);
        issue_b = issue_a && ib.i_is_valid[0] && !hit_b && !pair_block;
    end

    assign ib.o_issue_a  = issue_a;
    assign ib.o_issue_b  = issue_b;
    assign ib.o_usingNUM = 2'(issue_a) + 2'(issue_b);
    assign o_serial_busy = (state != S_NORMAL);

    // A memory pair never co-issues, so at most one of these is set.
    assign push_a = issue_a && ib.a_is_load && ib.a_rf_we && (ib.a_rf_rd != 5'd0);
    assign push_b = issue_b && ib.b_is_load && ib.b_rf_we && (ib.b_rf_rd != 5'd0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sb_vld <= '0;
            for (int i = 0; i < SB_N; i++) sb_rd[i] <= 5'd0;
        end else if (flush_BR) begin
            sb_vld <= '0;
        end else if (!stall) begin
            sb_vld[0] <= push_a | push_b;
            sb_rd[0]  <= push_b ? ib.b_rf_rd : ib.a_rf_rd;
            for (int i = 1; i < SB_N; i++) begin
                sb_vld[i] <= sb_vld[i-1];
                sb_rd[i]  <= sb_rd[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_NORMAL;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (flush_BR) begin
            state_nxt = S_NORMAL;
            cnt_nxt   = 4'd0;
        end else begin
            case (state)
                S_NORMAL: begin
                    if (issue_a && ib.a_is_serial) begin
                        state_nxt = S_DRAIN;
                        cnt_nxt   = DRAIN_INIT;
                    end
                end
                S_DRAIN: begin
                    // The last drain cycle is the one that observes cnt == 1.
                    if (!stall) begin
                        if (cnt == 4'd1) begin
                            state_nxt = S_NORMAL;
                            cnt_nxt   = 4'd0;
                        end else begin
                            cnt_nxt = cnt - 4'd1;
                        end
                    end
                end
                default: begin
                    state_nxt = S_NORMAL;
                    cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_cnt_dual   <= 32'd0;
            o_cnt_single <= 32'd0;
            o_cnt_zero   <= 32'd0;
        end else if (ib.o_usingNUM == 2'd2) begin
            o_cnt_dual <= o_cnt_dual + 32'd1;
        end else if (ib.o_usingNUM == 2'd1) begin
            o_cnt_single <= o_cnt_single + 32'd1;
        end else if (ib.i_is_valid != 2'b00) begin
            o_cnt_zero <= o_cnt_zero + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// tb/tb_issue_ctrl.sv - randomized self-checking bench for issue_ctrl
module tb_issue_ctrl;

    localparam int LOAD_LAT     = 2;
    localparam int SERIAL_DRAIN = 3;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] r1;
        logic [4:0] r2;
        logic       we;
        logic       load;
        logic       mem;
        logic       br;
        logic       md;
        logic       serial;
    } ins_t;

    logic clk;
    logic rstn;
    logic flush_br;
    logic stall_dc;
    logic stall_dv;
    logic busy;
`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] cnt_dual, cnt_single, cnt_zero;
`endif

    issue_if bus ();

    issue_ctrl #(.LOAD_LAT(LOAD_LAT), .SERIAL_DRAIN(SERIAL_DRAIN)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .ib           (bus),
        .flush_BR     (flush_br),
        .stall_DCache (stall_dc),
        .stall_div    (stall_dv),
        .o_serial_busy(busy)
`ifdef ISSUE_PERF_CNT_EN
        ,
        .o_cnt_dual   (cnt_dual),
        .o_cnt_single (cnt_single),
        .o_cnt_zero   (cnt_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per-register count of unstalled cycles until a loaded
    // value is usable, and remaining drain cycles.
    int pend [32];
    int drain_left;
    int m_dual, m_single, m_zero;

    int n_chk;
    int n_pass;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic bit pending(input logic [4:0] r);
        return (r != 5'd0) && (pend[r] > 0);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) pend[r] = 0;
        drain_left = 0;
        m_dual = 0; m_single = 0; m_zero = 0;
    endtask

    task automatic drive(input logic [1:0] v, input ins_t a, input ins_t b);
        bus.i_is_valid  = v;
        bus.a_rf_rd     = a.rd;  bus.b_rf_rd     = b.rd;
        bus.a_rf_we     = a.we;  bus.b_rf_we     = b.we;
        bus.a_rf_raddr1 = a.r1;  bus.a_rf_raddr2 = a.r2;
        bus.b_rf_raddr1 = b.r1;  bus.b_rf_raddr2 = b.r2;
        bus.a_is_load   = a.load; bus.b_is_load  = b.load;
        bus.a_is_mem    = a.mem;  bus.b_is_mem   = b.mem;
        bus.a_is_br     = a.br;   bus.b_is_br    = b.br;
        bus.a_is_muldiv = a.md;   bus.b_is_muldiv = b.md;
        bus.a_is_serial = a.serial; bus.b_is_serial = b.serial;
    endtask

    // One clock: drive, compare against the model, then advance the model.
    task automatic cycle(input string tag, input logic [1:0] v, input ins_t a, input ins_t b,
                         input logic fl, input logic sd, input logic sv,
                         output logic [1:0] num, output logic bsy);
        bit stl, any, ea, eb, blk;
        int n;
        @(negedge clk);
        drive(v, a, b);
        flush_br = fl; stall_dc = sd; stall_dv = sv;
        #1;
        stl = sd | sv;
        any = 0;
        for (int r = 1; r < 32; r++) if (pend[r] > 0) any = 1;
        ea = v[1] && !stl && !fl && (drain_left == 0)
             && !pending(a.r1) && !pending(a.r2) && !(a.serial && any);
        blk = (a.we && a.rd != 0 && (a.rd == b.r1 || a.rd == b.r2))
              || (a.mem && b.mem) || a.br || (a.md && b.md) || a.serial || b.serial;
        eb = ea && v[0] && !pending(b.r1) && !pending(b.r2) && !blk;
        n = int'(ea) + int'(eb);
        num = bus.o_usingNUM;
        bsy = busy;
        chk({tag, ".num"},  32'(bus.o_usingNUM), 32'(n));
        chk({tag, ".ia"},   32'(bus.o_issue_a), 32'(ea));
        chk({tag, ".ib"},   32'(bus.o_issue_b), 32'(eb));
        chk({tag, ".busy"}, 32'(busy), 32'(drain_left > 0));
        @(posedge clk);
        if (n == 2) m_dual++;
        else if (n == 1) m_single++;
        else if (v != 2'b00) m_zero++;
        if (fl) begin
            for (int r = 0; r < 32; r++) pend[r] = 0;
            drain_left = 0;
        end else begin
            if (!stl) begin
                for (int r = 0; r < 32; r++) if (pend[r] > 0) pend[r]--;
                if (drain_left > 0) drain_left--;
            end
            if (ea && a.serial) drain_left = SERIAL_DRAIN;
            if (ea && a.load && a.we && a.rd != 0) pend[a.rd] = LOAD_LAT - 1;
            if (eb && b.load && b.we && b.rd != 0) pend[b.rd] = LOAD_LAT - 1;
        end
    endtask

    function automatic ins_t mk(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                                input logic we, input logic load, input logic serial);
        ins_t t;
        t = '0;
        t.rd = rd; t.r1 = r1; t.r2 = r2; t.we = we;
        t.load = load; t.mem = load; t.serial = serial;
        return t;
    endfunction

    function automatic ins_t rnd_ins();
        ins_t t;
        t.rd     = 5'($urandom_range(0, 3));
        t.r1     = 5'($urandom_range(0, 3));
        t.r2     = 5'($urandom_range(0, 3));
        t.we     = ($urandom_range(0, 3) != 0);
        t.load   = ($urandom_range(0, 3) == 0);
        t.mem    = t.load | ($urandom_range(0, 3) == 0);
        t.br     = ($urandom_range(0, 5) == 0);
        t.md     = ($urandom_range(0, 4) == 0);
        t.serial = ($urandom_range(0, 11) == 0);
        return t;
    endfunction

    task automatic chk_counters(input string tag);
`ifdef ISSUE_PERF_CNT_EN
        chk({tag, ".cdual"},   cnt_dual,   32'(m_dual));
        chk({tag, ".csingle"}, cnt_single, 32'(m_single));
        chk({tag, ".czero"},   cnt_zero,   32'(m_zero));
`else
        chk({tag, ".busy"}, 32'(busy), 32'(drain_left > 0));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ins_t add_a, sub_b, use_r4, ld8, use8, csr, sld8, nop;
        logic [1:0] num;
        logic bsy;
        n_chk = 0; n_pass = 0;
        model_reset();
        nop    = '0;
        add_a  = mk(5'd4,  5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
        sub_b  = mk(5'd5,  5'd6, 5'd7, 1'b1, 1'b0, 1'b0);
        use_r4 = mk(5'd9,  5'd4, 5'd7, 1'b1, 1'b0, 1'b0);
        ld8    = mk(5'd8,  5'd1, 5'd0, 1'b1, 1'b1, 1'b0);
        use8   = mk(5'd10, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0);
        csr    = mk(5'd11, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1);
        sld8   = mk(5'd8,  5'd1, 5'd0, 1'b1, 1'b1, 1'b1);

        // Reset with a valid pair at the head: everything stays quiet.
        rstn = 1'b0; flush_br = 1'b0; stall_dc = 1'b0; stall_dv = 1'b0;
        drive(2'b11, add_a, sub_b);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.num",  32'(bus.o_usingNUM), 32'd0);
        chk("rst.ia",   32'(bus.o_issue_a), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk_counters("rst");
        drive(2'b00, nop, nop);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rel.num", 32'(bus.o_usingNUM), 32'd0);

        // Independent pair dual-issues every cycle.
        repeat (3) begin
            cycle("indep", 2'b11, add_a, sub_b, 0, 0, 0, num, bsy);
            chk("indep.k", 32'(num), 32'd2);
        end

        // RAW inside the pair splits it; B then issues from slot A.
        cycle("raw", 2'b11, add_a, use_r4, 0, 0, 0, num, bsy);
        chk("raw.k", 32'(num), 32'd1);
        cycle("raw2", 2'b10, use_r4, nop, 0, 0, 0, num, bsy);
        chk("raw2.k", 32'(num), 32'd1);

        // Load-use: one bubble.
        cycle("ld", 2'b10, ld8, nop, 0, 0, 0, num, bsy);
        chk("ld.k", 32'(num), 32'd1);
        cycle("lu1", 2'b10, use8, nop, 0, 0, 0, num, bsy);
        chk("lu1.k", 32'(num), 32'd0);
        cycle("lu2", 2'b10, use8, nop, 0, 0, 0, num, bsy);
        chk("lu2.k", 32'(num), 32'd1);

        // Load-use with stall: scoreboard holds through the stall.
        cycle("lds", 2'b10, ld8, nop, 0, 0, 0, num, bsy);
        for (int i = 0; i < 3; i++) begin
            cycle("lus", 2'b10, use8, nop, 0, i[0], !i[0], num, bsy);
            chk("lus.k", 32'(num), 32'd0);
        end
        cycle("lus3", 2'b10, use8, nop, 0, 0, 0, num, bsy);
        chk("lus3.k", 32'(num), 32'd0);
        cycle("lus4", 2'b10, use8, nop, 0, 0, 0, num, bsy);
        chk("lus4.k", 32'(num), 32'd1);

        // Serializing instruction issues alone and drains for 3 cycles.
        cycle("ser", 2'b11, csr, sub_b, 0, 0, 0, num, bsy);
        chk("ser.k", 32'(num), 32'd1);
        for (int i = 0; i < SERIAL_DRAIN; i++) begin
            cycle("drn", 2'b11, add_a, sub_b, 0, 0, 0, num, bsy);
            chk("drn.k", 32'(num), 32'd0);
            chk("drn.b", 32'(bsy), 32'd1);
        end
        cycle("post", 2'b11, add_a, sub_b, 0, 0, 0, num, bsy);
        chk("post.k", 32'(num), 32'd2);
        chk("post.b", 32'(bsy), 32'd0);

        // Flush mid-drain with a load in the scoreboard.
        cycle("sld", 2'b10, sld8, nop, 0, 0, 0, num, bsy);
        chk("sld.k", 32'(num), 32'd1);
        cycle("sst", 2'b10, use8, nop, 0, 1, 0, num, bsy);
        cycle("sfl", 2'b10, use8, nop, 1, 1, 0, num, bsy);
        chk("sfl.k", 32'(num), 32'd0);
        cycle("saf", 2'b10, use8, nop, 0, 0, 0, num, bsy);
        chk("saf.k", 32'(num), 32'd1);
        chk("saf.b", 32'(bsy), 32'd0);
        chk_counters("dir");

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cycle("rnd", 2'($urandom_range(0, 3)), rnd_ins(), rnd_ins(),
                  ($urandom_range(0, 11) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 7) == 0), num, bsy);
        end
        chk_counters("rnd");

        // Asynchronous reset mid-drain.
        cycle("ar.ser", 2'b10, csr, nop, 0, 0, 0, num, bsy);
        if (drain_left == 0) cycle("ar.ser2", 2'b10, csr, nop, 1, 0, 0, num, bsy);
        if (drain_left == 0) cycle("ar.ser3", 2'b10, csr, nop, 0, 0, 0, num, bsy);
        @(negedge clk);
        drive(2'b11, add_a, sub_b);
        flush_br = 1'b0; stall_dc = 1'b0; stall_dv = 1'b0;
        #1;
        chk("ar.pre", 32'(busy), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        chk("ar.num",  32'(bus.o_usingNUM), 32'd0);
        chk("ar.busy", 32'(busy), 32'd0);
        chk_counters("ar");
        drive(2'b00, nop, nop);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++)
            cycle("ar.post", 2'b11, add_a, sub_b, 0, 0, 0, num, bsy);
        chk_counters("end");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
